rr_mux_arbiter: RTL and testbench

//   Round-robin arbiter that shares one N-bit datapath among S requesters.

---
 rtl/rr_mux_arbiter.sv | 164 ++++++++++++++++
 tb/tb_rr_mux_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter sharing one N-bit datapath among S requesters. One
//   valid requester is granted per cycle, its word is steered through a
//   binary mux tree and registered into a single output slot that uses a
//   valid/ready handshake. Burst locking keeps a requester granted for up
//   to MAX_BURST consecutive beats before the round-robin search moves on.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset
//   req_valid_i  [S]    requester i has a word
//   req_data_i   [S*N]  word i at [N*(i+1)-1:N*i]
//   req_ready_o  [S]    one-hot (or zero) accept strobe, combinational
//   out_valid_o         output slot holds a word
//   out_data_o   [N]    registered word
//   out_src_o    [SW]   index of the requester that supplied out_data_o
//   out_ready_i         downstream accepts when out_valid_o & out_ready_i
//   sel_o        [SW]   current mux select (granted index, else last grant)
module rr_mux_arbiter #(
  parameter int N         = 64,
  parameter int S         = 64,
  parameter int MAX_BURST = 4,
  localparam int SW       = $clog2(S)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [S-1:0]   req_valid_i,
  input  logic [S*N-1:0] req_data_i,
  output logic [S-1:0]   req_ready_o,
  output logic           out_valid_o,
  output logic [N-1:0]   out_data_o,
  output logic [SW-1:0]  out_src_o,
  input  logic           out_ready_i,
  output logic [SW-1:0]  sel_o
);

  localparam int P  = 1 << SW;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] last_q, last_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_src_q, out_src_d;

  logic          load_en, grant, lock_ok, burst_done, rr_found;
  logic [SW-1:0] owner_inc, base, rr_g, g;
  logic [SW:0]   idx;
  logic [N-1:0]  mux_out;

  assign load_en    = !out_valid_q | out_ready_i;
  assign grant      = !rst_i & load_en & (|req_valid_i);
  assign burst_done = (state_q == OWN) && (cnt_q >= CW'(MAX_BURST));
  assign lock_ok    = (state_q == OWN) && req_valid_i[owner_q] &&
                      (cnt_q < CW'(MAX_BURST));
  assign owner_inc  = (owner_q == SW'(S - 1)) ? '0 : owner_q + 1'b1;
  // An exhausted burst restarts the search just past the owner, so the
  // owner is only re-picked when nobody else is asking.
  assign base       = burst_done ? owner_inc : ptr_q;

  // Rotating first-valid search: base, base+1, ..., S-1, 0, ..., base-1.
  always_comb begin
    rr_found = 1'b0;
    rr_g     = '0;
    idx      = '0;
    for (int k = 0; k < S; k++) begin
      idx = {1'b0, base} + (SW + 1)'(k);
      if (idx >= (SW + 1)'(S)) idx = idx - (SW + 1)'(S);
      if (!rr_found && req_valid_i[idx[SW-1:0]]) begin
        rr_found = 1'b1;
        rr_g     = idx[SW-1:0];
      end
    end
  end

  assign g           = lock_ok ? owner_q : rr_g;
  assign req_ready_o = grant ? ({{(S-1){1'b0}}, 1'b1} << g) : '0;
  assign sel_o       = grant ? g : last_q;

  // Binary mux tree: level SW holds the (zero-padded) leaves, the root at
  // level 0 is steered by the select MSB.
  for (genvar d = 0; d <= SW; d++) begin : g_lvl
    logic [N-1:0] lv [1 << d];
    if (d == SW) begin : g_leaf
      for (genvar i = 0; i < P; i++) begin : g_i
        if (i < S) begin : g_used
          assign lv[i] = req_data_i[N*i +: N];
        end else begin : g_pad
          assign lv[i] = '0;
        end
      end
    end else begin : g_mux
      for (genvar i = 0; i < (1 << d); i++) begin : g_i
        assign lv[i] = g[SW-1-d] ? g_lvl[d+1].lv[2*i+1] : g_lvl[d+1].lv[2*i];
      end
    end
  end
  assign mux_out = g_lvl[0].lv[0];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_out;
      out_src_d   = g;
      last_d      = g;
      state_d     = OWN;
      if (state_q == OWN && g == owner_q && !burst_done) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        // New burst (new owner, or owner re-picked after exhausting).
        owner_d = g;
        cnt_d   = CW'(1);
        if (state_q == OWN) ptr_d = owner_inc;
      end
    end else if (load_en) begin
      if (out_ready_i) out_valid_d = 1'b0;
      if (state_q == OWN) begin
        state_d = IDLE;
        cnt_d   = '0;
        ptr_d   = owner_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: two instances (MAX_BURST=2 and 1) share the
// same stimulus; a behavioural model of the arbitration rules predicts
// req_ready/sel before each edge and the output slot after it.
module tb_rr_mux_arbiter;
  localparam int N = 8;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [S-1:0] rv;
  logic [S*N-1:0] rd;
  logic         ordy;
  logic [S-1:0] rr  [2];
  logic         ov  [2];
  logic [N-1:0] od  [2];
  logic [1:0]   os  [2];
  logic [1:0]   sel [2];

  always #5 clk = ~clk;

  rr_mux_arbiter #(.N(N), .S(S), .MAX_BURST(2)) u_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv), .req_data_i(rd),
    .req_ready_o(rr[0]), .out_valid_o(ov[0]), .out_data_o(od[0]),
    .out_src_o(os[0]), .out_ready_i(ordy), .sel_o(sel[0]));

  rr_mux_arbiter #(.N(N), .S(S), .MAX_BURST(1)) u_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(rv), .req_data_i(rd),
    .req_ready_o(rr[1]), .out_valid_o(ov[1]), .out_data_o(od[1]),
    .out_src_o(os[1]), .out_ready_i(ordy), .sel_o(sel[1]));

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference state: burst owner and beats used, search pointer, slot.
  int maxb  [2] = '{2, 1};
  int m_ptr [2] = '{0, 0};
  int m_own [2] = '{0, 0};
  int m_ownr[2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  int m_last[2] = '{0, 0};
  int m_ov  [2] = '{0, 0};
  int m_od  [2] = '{0, 0};
  int m_os  [2] = '{0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    int g[2];
    int gr[2];
    int ld[2];
    #1;
    for (int m = 0; m < 2; m++) begin
      ld[m] = (m_ov[m] == 0) || ordy;
      gr[m] = (!rst && ld[m] && rv != 0) ? 1 : 0;
      g[m]  = 0;
      if (m_own[m] != 0 && rv[m_ownr[m]] && m_cnt[m] < maxb[m]) g[m] = m_ownr[m];
      else begin
        int b;
        int hit;
        b   = (m_own[m] != 0 && m_cnt[m] >= maxb[m]) ? (m_ownr[m] + 1) % S : m_ptr[m];
        hit = 0;
        for (int k = 0; k < S; k++)
          if (!hit && rv[(b + k) % S]) begin hit = 1; g[m] = (b + k) % S; end
      end
      chk($sformatf("req_ready%0d", m), rr[m], gr[m] ? (32'd1 << g[m]) : 32'd0);
      if (!rst) chk($sformatf("sel%0d", m), sel[m], gr[m] ? g[m] : m_last[m]);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_ptr[m] = 0; m_own[m] = 0; m_ownr[m] = 0; m_cnt[m] = 0;
        m_last[m] = 0; m_ov[m] = 0; m_od[m] = 0; m_os[m] = 0;
      end else if (gr[m] != 0) begin
        m_ov[m] = 1; m_od[m] = (rd >> (N * g[m])) & 8'hFF; m_os[m] = g[m];
        m_last[m] = g[m];
        if (m_own[m] != 0 && g[m] == m_ownr[m] && m_cnt[m] < maxb[m]) m_cnt[m]++;
        else begin
          if (m_own[m] != 0) m_ptr[m] = (m_ownr[m] + 1) % S;
          m_ownr[m] = g[m]; m_cnt[m] = 1;
        end
        m_own[m] = 1;
      end else if (ld[m] != 0) begin
        if (ordy) m_ov[m] = 0;
        if (m_own[m] != 0) begin
          m_own[m] = 0; m_cnt[m] = 0; m_ptr[m] = (m_ownr[m] + 1) % S;
        end
      end
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("out_valid%0d", m), ov[m], m_ov[m]);
      chk($sformatf("out_data%0d", m), od[m], m_od[m]);
      chk($sformatf("out_src%0d", m), os[m], m_os[m]);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_fair_a[5] = '{0, 0, 1, 1, 2};
    int exp_fair_b[5] = '{0, 1, 2, 3, 0};
    int exp_burst[6]  = '{2, 2, 3, 3, 2, 2};
    int exp_wrap[3]   = '{1, 1, 0};

    rst = 1'b1; rv = 4'hF; ordy = 1'b1;
    rd  = {8'h13, 8'h12, 8'h11, 8'h10};

    // Reset with every requester asking: no accepts, slot empty.
    do_reset(2);
    chk("reset_out_valid", ov[0], 0);

    // Fair rotation, all valid, sink always ready.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fair_src_a", os[0], exp_fair_a[i]);
      chk("fair_src_b", os[1], exp_fair_b[i]);
      chk("fair_data_b", od[1], 8'h10 + exp_fair_b[i]);
    end

    // Burst locking between two requesters.
    do_reset(1);
    rv = 4'b1100;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("burst_src", os[0], exp_burst[i]);
    end

    // Backpressure: slot holds, no accepts; release overlaps next grant.
    do_reset(1);
    rv = 4'hF; ordy = 1'b0;
    step();
    repeat (4) begin
      step();
      chk("bp_hold_data", od[0], 8'h10);
      chk("bp_no_ready", rr[0], 0);
    end
    ordy = 1'b1;
    step();
    chk("bp_release_src_a", os[0], 0);
    chk("bp_release_src_b", os[1], 1);

    // Pointer wrap: park ptr at 3 via an idle cycle after granting 2.
    do_reset(1);
    rv = 4'b0100; step();
    rv = 4'b0000; step();
    rv = 4'b0010; step(); chk("wrap_src", os[0], exp_wrap[0]);
    rv = 4'b0011; step(); chk("wrap_src", os[0], exp_wrap[1]);
    step();               chk("wrap_src", os[0], exp_wrap[2]);

    // Reset in the middle of a burst restarts the rotation at 0.
    rv = 4'b0100; step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_out_valid", ov[0], 0);
    rv = 4'hF; step();
    chk("midrst_src", os[0], 0);

    // Random traffic with backpressure and occasional reset.
    for (int i = 0; i < 400; i++) begin
      rv   = 4'($urandom);
      rd   = 32'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 49) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
